// File: rtl/cdc_bus_receiver_pkg.sv
// Shared types and limits for the toggle-handshake bus crossing.
package cdc_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

  // 2'b11 is unused and steers back to EMPTY.
  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    FULL      = 2'b01,
    FULL_PEND = 2'b10
  } state_e;

  function automatic bit sync_stages_ok(int n);
    return (n >= MIN_SYNC_STAGES) && (n <= MAX_SYNC_STAGES);
  endfunction

endpackage

// File: rtl/cdc_bus_receiver_if.sv
// Bus bundle between the toggle source, this receiver and the downstream sink.
interface cdc_bus_receiver_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] src_data;
  logic                 src_toggle;
  logic [BUS_WIDTH-1:0] dst_data;
  logic                 dst_valid;
  logic                 dst_ready;
  logic                 ack_toggle;
  logic                 overrun;
  logic                 overrun_clr;

  // Receiver view.
  modport slave (
    input  src_data, src_toggle, dst_ready, overrun_clr,
    output dst_data, dst_valid, ack_toggle, overrun
  );

  // Source / sink view.
  modport master (
    output src_data, src_toggle, dst_ready, overrun_clr,
    input  dst_data, dst_valid, ack_toggle, overrun
  );
endinterface

// File: rtl/cdc_bus_receiver_toggle_sync.sv
// Toggle synchronizer with edge detect; also usable on the source side for the ack.
module toggle_sync
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_toggle,
  output logic o_event,
  output logic o_lvl
);

  if (!sync_stages_ok(NUM_STAGES)) begin : g_bad_stages
    $error("toggle_sync: NUM_STAGES out of range");
  end

  logic [NUM_STAGES-1:0] r_sync;
  logic                  r_prev;

  // Shift the async level through the chain; keep the last synced value for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[NUM_STAGES-2:0], i_toggle};
      r_prev <= r_sync[NUM_STAGES-1];
    end
  end

  assign o_lvl   = r_sync[NUM_STAGES-1];
  assign o_event = r_sync[NUM_STAGES-1] ^ r_prev;

endmodule

// File: rtl/cdc_bus_receiver.sv
// Destination end of the toggle-handshake crossing with a one-word skid slot.
module cdc_bus_receiver
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  cdc_bus_receiver_if.slave  bus
);

  if (!sync_stages_ok(NUM_STAGES)) begin : g_bad_stages
    $error("cdc_bus_receiver: NUM_STAGES out of range");
  end

  state_e               r_state, w_state_nxt;
  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_vld, w_vld_nxt;
  logic                 r_ack, w_ack_nxt;
  logic                 r_pend_lvl;
  logic                 r_ovr;
  logic                 w_cap, w_pend_set, w_ovr_set;
  logic                 w_event, w_lvl;

  toggle_sync #(.NUM_STAGES(NUM_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_toggle (bus.src_toggle),
    .o_event  (w_event),
    .o_lvl    (w_lvl)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Next state and datapath controls. A word seen while stalled is left on the
  // source bus (no ack yet), so only its level is remembered.
  always_comb begin
    w_state_nxt = r_state;
    w_vld_nxt   = r_vld;
    w_ack_nxt   = r_ack;
    w_cap       = 1'b0;
    w_pend_set  = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_event) begin
          w_cap       = 1'b1;
          w_vld_nxt   = 1'b1;
          w_ack_nxt   = w_lvl;
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (bus.dst_ready && !w_event) begin
          w_vld_nxt   = 1'b0;
          w_state_nxt = EMPTY;
        end else if (bus.dst_ready && w_event) begin
          w_cap       = 1'b1;
          w_ack_nxt   = w_lvl;
        end else if (w_event) begin
          w_pend_set  = 1'b1;
          w_state_nxt = FULL_PEND;
        end
      end
      FULL_PEND: begin
        if (bus.dst_ready) begin
          w_cap       = 1'b1;
          w_ack_nxt   = r_pend_lvl;
          w_state_nxt = FULL;
        end
        w_ovr_set = w_event;
      end
      default: begin
        w_vld_nxt   = 1'b0;
        w_state_nxt = EMPTY;
      end
    endcase
  end

  // Output word, valid, ack level and pending level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data     <= '0;
      r_vld      <= 1'b0;
      r_ack      <= 1'b0;
      r_pend_lvl <= 1'b0;
    end else begin
      if (w_cap)      r_data     <= bus.src_data;
      if (w_pend_set) r_pend_lvl <= w_lvl;
      r_vld <= w_vld_nxt;
      r_ack <= w_ack_nxt;
    end
  end

  // Sticky overrun; a new violation wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_ovr <= 1'b0;
    else if (w_ovr_set)       r_ovr <= 1'b1;
    else if (bus.overrun_clr) r_ovr <= 1'b0;
  end

  assign bus.dst_data   = r_data;
  assign bus.dst_valid  = r_vld;
  assign bus.ack_toggle = r_ack;
  assign bus.overrun    = r_ovr;

endmodule

// File: doc/cdc_bus_receiver.md
Name: cdc_bus_receiver

Overview:
- Destination-domain end of the team's toggle-handshake bus crossing, running in the `clk` domain.
- The source holds `src_data` stable and flips `src_toggle` once per word.
- This block synchronizes the toggle, captures the word and presents it downstream on a valid/ready interface.
- It returns `ack_toggle` to the source, which the source synchronizes before sending its next word.
- A one-word skid slot absorbs a word arriving while downstream stalls; a protocol violation beyond that sets a sticky overrun flag.

Parameters:
- NUM_STAGES, 2, flops in the toggle synchronizer chain; legal values 2..4.
- BUS_WIDTH, 8, width of the transferred word.

Ports:
- clk  in  1  destination clock.
- rst  in  1  reset, asynchronous, active-low; clock clk.
- src_data  in  BUS_WIDTH  source word; stable from its toggle until the source sees the matching ack.
- src_toggle  in  1  source-domain level; each transition marks a new word.
- dst_data  out  BUS_WIDTH  captured word.
- dst_valid  out  1  dst_data holds an unconsumed word.
- dst_ready  in  1  downstream accepts; a transfer occurs when dst_valid && dst_ready.
- ack_toggle  out  1  level equal to the toggle value of the most recently captured word.
- overrun  out  1  sticky protocol-violation flag.
- overrun_clr  in  1  synchronous clear for overrun.

Behaviour:
- Reset values (asynchronous, rst low): sync chain = 0, tog_prev = 0, state = EMPTY, dst_data = 0, dst_valid = 0, ack_toggle = 0, overrun = 0, pending level = 0.
- Synchronizer:
  - sync[0] <= src_toggle, sync[i] <= sync[i-1], tog_prev <= sync[NUM_STAGES-1].
  - event = sync[NUM_STAGES-1] ^ tog_prev; it is a single-cycle pulse per source transition. lvl = sync[NUM_STAGES-1].
- Latency: a src_toggle transition sampled at edge k gives event during the cycle after edge k+NUM_STAGES-1. Capture happens at edge k+NUM_STAGES, so dst_valid is high after NUM_STAGES+1 edges counting edge k.
- State machine, states EMPTY, FULL, FULL_PEND:
  - EMPTY, event: dst_data <= src_data, dst_valid <= 1, ack_toggle <= lvl; go to FULL.
  - FULL, dst_ready && !event: dst_valid <= 0; go to EMPTY.
  - FULL, dst_ready && event: capture the new word (back-to-back) and update ack_toggle; stay in FULL with dst_valid = 1.
  - FULL, !dst_ready && event: record pend_lvl <= lvl; do not capture and do not update ack. Go to FULL_PEND. Source data is still stable because no ack has been sent.
  - FULL_PEND, dst_ready: dst_data <= src_data, ack_toggle <= pend_lvl; go to FULL with dst_valid held at 1.
  - FULL_PEND, event (any dst_ready): overrun <= 1. The extra event is discarded, and the ready handling of FULL_PEND still applies.
- dst_data is stable while dst_valid = 1 and dst_ready = 0.
- ack_toggle changes only at a capture, and changes at most once per capture.
- overrun:
  - set has priority over overrun_clr in the same cycle.
  - it is otherwise cleared when overrun_clr = 1.
  - it never affects the data path.
- Reset mid-transfer: everything returns to reset values and any held word is lost. The source must sit in the same reset domain and return src_toggle to 0. If src_toggle is 1 at reset release, one event is generated and treated as a new word.
- No combinational path from any input to any output.

Decomposition:
- Package cdc_pkg:
  - state encoding: EMPTY = 2'b00, FULL = 2'b01, FULL_PEND = 2'b10; 2'b11 recovers to EMPTY.
  - constants MIN_SYNC_STAGES = 2 and MAX_SYNC_STAGES = 4, with an elaboration check on NUM_STAGES.
- Sub-module toggle_sync (parameter NUM_STAGES): holds the sync chain and tog_prev, and outputs event and lvl. It is reusable by the source side for ack_toggle.

Test Plan:
1. NUM_STAGES=2, dst_ready=1, src_data=8'hA5, src_toggle 0->1 → dst_valid high 3 edges after the sampling edge with dst_data=8'hA5; ack_toggle=1 on the same edge; dst_valid low one cycle later.
2. dst_ready=0, word 8'h3C delivered, then source flips toggle with 8'h5A after seeing the ack → dst_data holds 8'h3C and state goes to FULL_PEND; ack_toggle stays 1. Raise dst_ready → 8'h3C transfers, 8'h5A is captured next edge and ack_toggle becomes 0.
3. In FULL_PEND, force a third toggle flip without waiting for ack → overrun=1 and stays 1. Assert overrun_clr → 0 next edge. Assert overrun_clr together with another violation → overrun stays 1.
4. Streaming with dst_ready=1: 16 words 8'h00..8'h0F, source waits for ack each time → all 16 received in order with no overrun, and ack_toggle parity equals the word count.
5. Assert rst low while in FULL holding 8'hFF → all outputs 0 immediately (asynchronously). Release with src_toggle=0 → no dst_valid. Repeat the release with src_toggle=1 → exactly one word captured.
6. NUM_STAGES=4 repeat of scenario 1 → dst_valid after 5 edges; event pulse is exactly one cycle wide.
